// File: rtl/wordmux_rr.sv
// wordmux_rr: registered N-channel word selector with direct or round-robin
// channel selection and a one-entry valid/ready output stage.
module wordmux_rr #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [CHANNELS-1:0]       i_valid,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic [CHANNELS-1:0]       o_ready,
  output logic                      o_valid,
  output logic [WIDTH-1:0]          o_data,
  output logic [SEL_W-1:0]          o_chan,
  input  logic                      i_ready
);

  // Pointer reset value makes the first round-robin search start at channel 0.
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(CHANNELS - 1);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0] chan_q,  chan_d;
  logic [SEL_W-1:0] last_q,  last_d;

  logic             can_load;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_word;

  assign can_load = !valid_q || i_ready;

  // Grant: explicit select in direct mode, first valid after last in RR mode.
  // Comparing against every legal index keeps out-of-range selects grant-free.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!i_mode) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if ((i_sel == SEL_W'(k)) && i_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(k);
        end
      end
    end else begin
      for (int unsigned j = 1; j <= CHANNELS; j++) begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          if (!grant_vld && (k == ((32'(last_q) + j) % CHANNELS)) && i_valid[k]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(k);
          end
        end
      end
    end
  end

  // Word multiplexer driven by the granted index.
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        sel_word = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot accept strobe; the only path from i_ready lands here.
  always_comb begin
    o_ready = '0;
    if (!i_rst && can_load && grant_vld) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        o_ready[k] = (grant_idx == SEL_W'(k));
      end
    end
  end

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    last_d  = last_q;
    if (can_load) begin
      if (grant_vld) begin
        valid_d = 1'b1;
        data_d  = sel_word;
        chan_d  = grant_idx;
        if (i_mode) begin
          last_d = grant_idx;
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any held word immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= LAST_RST;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_chan  = chan_q;

endmodule

// File: tb/tb_wordmux_rr.sv
// Scoreboard bench for wordmux_rr: stimulus pushes expected words, a
// negedge monitor pops and compares on each output handshake.
module tb_wordmux_rr;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  vld;
  logic [15:0] ch [4];
  logic [63:0] data;
  logic [3:0]  o_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic [1:0]  o_chan;
  logic        rdy;

  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  vld3;
  logic [47:0] data3;
  logic [2:0]  o_ready3;
  logic        o_valid3;
  logic [15:0] o_data3;
  logic [1:0]  o_chan3;
  logic        rdy3;

  int checks = 0;
  int errors = 0;
  logic [17:0] sb [$];

  assign data = {ch[3], ch[2], ch[1], ch[0]};

  wordmux_rr #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel), .i_valid(vld),
    .i_data(data), .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
    .o_chan(o_chan), .i_ready(rdy)
  );

  wordmux_rr #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode3), .i_sel(sel3), .i_valid(vld3),
    .i_data(data3), .o_ready(o_ready3), .o_valid(o_valid3), .o_data(o_data3),
    .o_chan(o_chan3), .i_ready(rdy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the accept strobe, queue any accepted word.
  task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                      input logic r, input logic [3:0] exp_rdy, input string name);
    mode = m; sel = s; vld = v; rdy = r;
    #1;
    chk(name, 32'(o_ready), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      if (exp_rdy[k]) sb.push_back({ch[k], 2'(k)});
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every output handshake must match the oldest queued word.
  always @(negedge clk) begin
    if (!rst && o_valid && rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected actual=%h/%0d required=none", o_data, o_chan);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        chk("mon_data", 32'(o_data), 32'(e[17:2]));
        chk("mon_chan", 32'(o_chan), 32'(e[1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 1'b1; sel = '0; vld = 4'b1111; rdy = 1'b1;
    for (int k = 0; k < 4; k++) ch[k] = '0;
    mode3 = 1'b0; sel3 = '0; vld3 = '0; rdy3 = 1'b1;
    data3 = {16'h3002, 16'h3001, 16'h3000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_ready", 32'(o_ready), 32'h0);
    chk("rst_o_valid", 32'(o_valid), 32'h0);
    chk("rst_o_data",  32'(o_data),  32'h0);
    chk("rst_o_chan",  32'(o_chan),  32'h0);
    rst = 1'b0; vld = '0;
    @(posedge clk); #1;

    // Load a word, then reset mid-cycle: it must vanish without a clock edge.
    mode = 1'b0; sel = 2'd0; vld = 4'b0001; ch[0] = 16'hAAAA; rdy = 1'b0;
    #1;
    chk("pre_rst_ready", 32'(o_ready), 32'h1);
    @(posedge clk); #1;
    vld = '0;
    chk("pre_rst_valid", 32'(o_valid), 32'h1);
    chk("pre_rst_data",  32'(o_data),  32'hAAAA);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'h0);
    chk("async_rst_data",  32'(o_data),  32'h0);
    chk("async_rst_chan",  32'(o_chan),  32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Direct select of channel 2.
    ch[2] = 16'hBEEF;
    step(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, "direct_ready");
    step(1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, "direct_idle");
    chk("direct_drained", 32'(o_valid), 32'h0);

    // Round-robin fairness with all channels valid.
    for (int k = 0; k < 4; k++) ch[k] = 16'h1000 + 16'(k);
    for (int i = 0; i < 8; i++)
      step(1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (i % 4)), "rr_fair");

    // Skip and wrap: only channels 1 and 3 valid after a grant to 3.
    step(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, "rr_skip1");
    step(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, "rr_skip3");
    step(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, "rr_wrap1");

    // Backpressure: hold 1234 for three stalled cycles, then no-bubble reload.
    ch[0] = 16'h1234;
    step(1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, "bp_load");
    ch[0] = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, "bp_stall_ready");
      chk("bp_stall_data",  32'(o_data),  32'h1234);
      chk("bp_stall_valid", 32'(o_valid), 32'h1);
    end
    step(1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, "bp_release");
    chk("bp_nobubble_valid", 32'(o_valid), 32'h1);
    chk("bp_nobubble_data",  32'(o_data),  32'h5678);

    // Direct select of an invalid channel: no grant, stage drains and holds data.
    step(1'b0, 2'd1, 4'b0001, 1'b1, 4'b0000, "inv_sel_ready");
    chk("inv_sel_valid", 32'(o_valid), 32'h0);
    chk("inv_sel_data",  32'(o_data),  32'h5678);
    chk("inv_sel_chan",  32'(o_chan),  32'h0);

    // Mode switch keeps the pointer: RR grant 1, two direct ch3, RR resumes at 2.
    step(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, "ms_rr1");
    ch[3] = 16'h3333;
    step(1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, "ms_direct3a");
    ch[3] = 16'h3334;
    step(1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, "ms_direct3b");
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, "ms_rr_next");
    step(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, "drain_a");
    step(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, "drain_b");
    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("final_valid", 32'(o_valid), 32'h0);

    // Three-channel instance: out-of-range select, then RR wrap 2 -> 0.
    mode3 = 1'b0; sel3 = 2'd3; vld3 = 3'b111;
    #1;
    chk("c3_oor_ready", 32'(o_ready3), 32'h0);
    @(posedge clk); #1;
    chk("c3_oor_valid", 32'(o_valid3), 32'h0);
    chk("c3_oor_data",  32'(o_data3),  32'h0);
    chk("c3_oor_chan",  32'(o_chan3),  32'h0);
    sel3 = 2'd2;
    #1;
    chk("c3_dir_ready", 32'(o_ready3), 32'h4);
    @(posedge clk); #1;
    chk("c3_dir_data", 32'(o_data3), 32'h3002);
    chk("c3_dir_chan", 32'(o_chan3), 32'h2);
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("c3_rr_ready", 32'(o_ready3), 32'(1 << (i % 3)));
      @(posedge clk); #1;
      chk("c3_rr_chan", 32'(o_chan3), 32'(i % 3));
      chk("c3_rr_data", 32'(o_data3), 32'h3000 + 32'(i % 3));
    end
    vld3 = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
